// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Total line bits in one frame: start + data + stop.
  function automatic int frame_bits(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - N-flop synchronizer for a single asynchronous input
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through the flop chain; the last stage is the safe copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - unbuffered UART receiver with mid-bit sampling
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 4,
  parameter int DATA_BITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BW = $clog2(CLOCKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] BAUD_HALF = BW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

  uart_rx_state_t         r_state;
  logic [BW-1:0]          r_baud_cnt;
  logic [CW-1:0]          r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shreg;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_frame_err;

  logic                   w_rx_s;
  logic [DATA_BITS-1:0]   w_shreg_next;
  logic                   w_stop_sample;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  bit_sync #(
    .STAGES    (2),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // LSB arrives first, so new bits enter at the MSB and drift down.
  if (DATA_BITS == 1) begin : g_shift_one
    assign w_shreg_next = w_rx_s;
  end else begin : g_shift_many
    assign w_shreg_next = {w_rx_s, r_shreg[DATA_BITS-1:1]};
  end

  assign w_stop_sample = (r_state == STOP) && (r_baud_cnt == BAUD_LAST);

  // Frame FSM with baud and bit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud_cnt <= '0;
          if (w_rx_s == START_BIT) r_state <= START;
        end
        START: begin
          if (r_baud_cnt == BAUD_HALF) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            // A high line at mid start bit was only a glitch.
            r_state    <= (w_rx_s == START_BIT) ? DATA : IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
            r_shreg    <= w_shreg_next;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) r_state <= STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
            // Leaving at mid stop bit gives half a bit to catch the next start edge.
            r_state    <= (w_rx_s == STOP_BIT) ? IDLE : BREAK;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        BREAK: begin
          r_baud_cnt <= '0;
          // A held-low line must go high before another frame can start.
          if (w_rx_s == STOP_BIT) r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_baud_cnt <= '0;
        end
      endcase
    end
  end

  // Registered outputs: word and strobes are updated from the stop-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= w_stop_sample && (w_rx_s == STOP_BIT);
      r_frame_err <= w_stop_sample && (w_rx_s != STOP_BIT);
      if (w_stop_sample && (w_rx_s == STOP_BIT)) r_data <= r_shreg;
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

`ifdef FORMAL
  // Structural invariants of the counters and strobes.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (int'(r_baud_cnt) < CLOCKS_PER_BIT);
      assert (int'(r_bit_cnt) <= DATA_BITS);
      assert (!(r_valid && r_frame_err));
      if (r_valid && $past(rst_n)) assert ($past(r_state) == STOP);
      assert (frame_bits(DATA_BITS) == DATA_BITS + 2);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

  localparam int CPB = 4;
  localparam int DB  = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLOCKS_PER_BIT (CPB),
    .DATA_BITS      (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   valid_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic busy_seen = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a strobe appears.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (busy) busy_seen = 1'b1;
    if (rst_n && (valid || frame_err)) begin
      if (valid) valid_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b frame_err=%0b data=%0h expected no pulse",
                 valid, frame_err, data);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 16'({valid, frame_err}), e.is_err ? 16'h1 : 16'h2);
        check("pulse_data", 16'(data), 16'(e.data));
      end
    end
  end

  task automatic expect_ok(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [9:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      rx = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits({1'b1, b, 1'b0}, 10);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int         n0;
    logic [7:0] b;

    // Reset state
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 16'(data), 16'h0);
    check("reset_valid", 16'(valid), 16'h0);
    check("reset_frame_err", 16'(frame_err), 16'h0);
    check("reset_busy", 16'(busy), 16'h0);
    rst_n = 1'b1;
    idle(4);

    // Single frame 0xA5
    expect_ok(8'hA5);
    send_byte(8'hA5);
    idle(4);
    check("a5_busy_after", 16'(busy), 16'h0);
    check("a5_consumed", 16'(exp_q.size()), 16'h0);

    // Back-to-back 0x00, 0xFF
    n0 = valid_cyc.size();
    expect_ok(8'h00);
    expect_ok(8'hFF);
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(4);
    check("b2b_count", 16'(valid_cyc.size() - n0), 16'h2);
    if (valid_cyc.size() >= n0 + 2)
      check("b2b_interval", 16'(valid_cyc[n0+1] - valid_cyc[n0]), 16'd40);

    // One-cycle glitch: brief busy, no strobe
    busy_seen = 1'b0;
    rx = 1'b0;
    @(posedge clk);
    #1;
    idle(10);
    check("glitch_busy_seen", 16'(busy_seen), 16'h1);
    check("glitch_busy_after", 16'(busy), 16'h0);
    check("glitch_no_pulse", 16'(exp_q.size()), 16'h0);

    // 0x3C with stop held low for 20 cycles, then 0x5A
    expect_err(8'hFF);
    send_bits({1'b0, 8'h3C, 1'b0}, 9);
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(6);
    check("ferr_data_held", 16'(data), 16'hFF);
    check("ferr_busy_after", 16'(busy), 16'h0);
    expect_ok(8'h5A);
    send_byte(8'h5A);
    idle(4);

    // Reset during data bit 4 of 0xC3
    send_bits({1'b1, 8'hC3, 1'b0}, 5);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_data", 16'(data), 16'h0);
    check("abort_valid", 16'(valid), 16'h0);
    check("abort_frame_err", 16'(frame_err), 16'h0);
    check("abort_busy", 16'(busy), 16'h0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    expect_ok(8'h81);
    send_byte(8'h81);
    idle(4);
    check("after_abort_data", 16'(data), 16'h81);

    // Loopback stream of 256 random bytes
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      expect_ok(b);
      send_byte(b);
    end
    idle(8);
    check("loopback_all_received", 16'(exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Unbuffered UART receiver: the downstream partner of `uart_tx`. It recovers frames from the serial line and presents each received word on a parallel output, marked by a one-cycle strobe. Frame format matches the transmitter:
- one start bit (0);
- `DATA_BITS` data bits, LSB first;
- one stop bit (1).

The block sits between the board RX pin and any consumer logic (FIFO, command decoder). It has no flow control; the consumer must accept `valid` whenever it pulses.

## Interface
- `CLOCKS_PER_BIT`, default 4: clock cycles per bit (clk rate / baud rate). Must be ≥ 4; an even value is recommended.
- `DATA_BITS`, default 8: data bits per frame, 1–16.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `rx`  in  1: serial line, asynchronous to `clk`, idles high.
- `data`  out  `DATA_BITS`: last received word; held until the next good frame.
- `valid`  out  1: one-cycle pulse when `data` is updated by a good frame.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1: high while a frame is being received (any state other than IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`. The synchronizer flops reset to 1.
- Counters:
  - `baud_cnt`, width `$clog2(CLOCKS_PER_BIT)`.
  - `bit_cnt`, width `$clog2(DATA_BITS+1)`.
  - Shift register `shreg[DATA_BITS-1:0]`: shifts right, new bit enters at the MSB.
- State machine:
  - IDLE: `baud_cnt` = 0. If `rx_s` = 0, go to START.
  - START: `baud_cnt` increments. When `baud_cnt` == `CLOCKS_PER_BIT/2 - 1` (mid start bit), sample `rx_s`:
    - 1: false start (glitch); go to IDLE with no output.
    - 0: clear `baud_cnt` and `bit_cnt`; go to DATA.
  - DATA: `baud_cnt` wraps at `CLOCKS_PER_BIT-1`. At each wrap (mid data bit), shift `rx_s` into `shreg` and increment `bit_cnt`. After the `DATA_BITS`-th sample, go to STOP.
  - STOP: at `baud_cnt` == `CLOCKS_PER_BIT-1` (mid stop bit), sample `rx_s`:
    - 1: load `data` from `shreg`, pulse `valid`, go to IDLE.
    - 0: pulse `frame_err`; `data` is not updated; go to BREAK.
  - BREAK: wait until `rx_s` = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Returning to IDLE at mid stop bit leaves half a bit of margin, so back-to-back frames resynchronize on the next falling edge.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: state = IDLE, `data` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0, all counters 0, `shreg` = 0.
- `rst_n` asserted mid-frame aborts immediately. No `valid` or `frame_err` is emitted for the aborted frame. After release, the block waits in IDLE for the next falling edge.
- Synchronizer latency is 2 cycles; the cycle in which IDLE sees `rx_s` = 0 is cycle 0.
- Sample points relative to cycle 0:
  - Start bit: cycle `CLOCKS_PER_BIT/2`.
  - Data bit k (k = 0…`DATA_BITS-1`): cycle `CLOCKS_PER_BIT/2 + (k+1)·CLOCKS_PER_BIT`.
  - Stop bit: one further `CLOCKS_PER_BIT` after the last data sample.
- `valid` or `frame_err` is high in the cycle after the stop sample edge (registered outputs).
- `busy` rises in the cycle after IDLE sees `rx_s` = 0. It falls when the state returns to IDLE, including after a false start.
- Tolerance: with `CLOCKS_PER_BIT` = 4, sampling is within ±1 clock of bit centre. This covers a baud mismatch of about ±2.5% over a 10-bit frame.

## Structure
- Shared package `uart_pkg` contains:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;`
  - Shared frame constants (start bit = 0, stop bit = 1, bits per frame = `DATA_BITS + 2`).
- One sub-module: `bit_sync`, a parameterized N-flop synchronizer (default 2) with a reset value parameter. It is reusable for other async inputs.
- Counters, the FSM and output registers live in `uart_rx`.
- Formal properties in an `ifdef FORMAL` section:
  - `baud_cnt` < `CLOCKS_PER_BIT`.
  - `bit_cnt` ≤ `DATA_BITS`.
  - `valid` and `frame_err` are never both high.
  - `valid` implies the previous state was STOP.

## Test plan
All scenarios use `CLOCKS_PER_BIT` = 4 and `DATA_BITS` = 8.
- Drive frame 0xA5 on `rx` with exact timing. Expect one `valid` pulse with `data` = 0xA5, `frame_err` = 0, and `busy` low afterwards.
- Drive frames 0x00 then 0xFF back-to-back with no idle gap. Expect two `valid` pulses 40 cycles apart, with `data` = 0x00 then `data` = 0xFF.
- Drive a 1-cycle low glitch on idle `rx`. Expect `busy` to pulse briefly, with no `valid` and no `frame_err`.
- Drive 0x3C with the stop bit held low for 20 cycles. Expect one `frame_err`, `data` keeping its previous value, no new frame until `rx` returns high, then a following 0x5A frame received correctly.
- Pull `rst_n` low at data bit 4 of a frame. Expect all outputs 0 immediately and no pulse for that frame; the next frame 0x81 is received correctly.
- Loopback: `uart_tx` drives `rx`; send 256 random bytes. Expect every byte received in order with no `frame_err`.
